block_interleaver: RTL and testbench
====================================

// Module: block_interleaver
// PURPOSE
//  Transmit-side block interleaver. Sits directly upstream of the deinterleaver and feeds its in_bits/data_ready input.
//  Accepts a serial coded bitstream and writes each N=ROWS*COLS-bit block row-wise into a matrix.
//  Reads the block column-wise and emits it as SYM_W-bit symbols, one per cycle.
//  A ping-pong (two-bank) buffer lets block k+1 fill while block k drains.
// PARAMETERS
//  ROWS   8   matrix rows
//  COLS   16  matrix columns; N = ROWS*COLS = 128 bits per block
//  SYM_W  4   output symbol width; N must be a multiple of SYM_W
// PORTS
//  clk         in   1      single clock; all logic on rising edge
//  reset       in   1      synchronous, active-high reset
//  in_valid    in   1      in_bit is valid this cycle
//  in_bit      in   1      serial input bit, block order n = 0..N-1
//  in_ready    out  1      block can accept in_bit this cycle
//  data_ready  out  1      out_bits valid this cycle (no backpressure)
//  out_bits    out  SYM_W  interleaved symbol, earliest bit on MSB
// BEHAVIOUR
//  - Input accept: an input bit is accepted on a rising edge where in_valid && in_ready.
//    Accepted bit n goes to bank wr_bank at row r = n/COLS, column c = n%COLS.
//  - Write progress: wr_cnt counts 0..N-1. On accepting bit N-1:
//    - full[wr_bank] <= 1
//    - wr_bank toggles
//    - wr_cnt <= 0
//  - in_ready = ~full[wr_bank] (combinational). It drops only when both banks are full.
//  - Output order: interleaved index m = c*ROWS + r.
//    Symbol k carries m = SYM_W*k .. SYM_W*k+SYM_W-1, with m = SYM_W*k on out_bits[SYM_W-1].
//    N/SYM_W = 32 symbols per block.
//  - Read FSM has two states, IDLE and EMIT:
//    - IDLE: if full[rd_bank], go to EMIT with sym_cnt = 0.
//    - EMIT: register one symbol per cycle; data_ready = 1 for exactly N/SYM_W consecutive cycles.
//    - After the last symbol: clear full[rd_bank] and toggle rd_bank.
//      If the new rd_bank is full, stay in EMIT back-to-back with no gap; otherwise go to IDLE.
//  - Latency: last bit of a block accepted at edge t means the first symbol is valid with data_ready = 1 after edge t+1.
//  - Outputs are registered. Between bursts, data_ready = 0 and out_bits = 0.
//  - Bank clear on the same edge as a write to the other bank: both take effect. There is no conflict, because read and write never target the same bank.
//  - Gaps in in_valid pause the write count only. Symbol content does not depend on input timing.
//  - reset (any time, including mid-block or mid-burst) takes effect on the next edge:
//    - wr_cnt, sym_cnt, wr_bank, rd_bank <= 0
//    - full[1:0] <= 0
//    - FSM <= IDLE
//    - data_ready <= 0, out_bits <= 0
//    - in_ready = 1
//    A partial block is discarded. Memory contents are not reset and do not need to be.
// TESTING
//  1. One block of 128'h3C3C_C3C3_CCCC_3333_C5AC_368C_0DDE_3EFC, MSB first, in_valid held high
//     -> 32 symbols matching the model; symbol0 = 4'h6, symbol1 = 4'h8; first data_ready one cycle after bit 127.
//  2. All-zero block except input bit n=17 = 1
//     -> symbol2 = 4'b0100 (m=9); every other symbol = 0.
//  3. Two blocks back-to-back, in_valid continuously high
//     -> in_ready never drops; two 32-cycle bursts; each burst equals its block's model output.
//  4. Same block with pseudo-random in_valid gaps
//     -> output symbols identical to scenario 1.
//  5. reset pulsed after 60 accepted bits, then a full block
//     -> no data_ready for the partial block; the full block comes out per the model.
//  6. Loopback into deinterleaver (same ROWS/COLS/SYM_W)
//     -> deinterleaver data_out reproduces the original 128-bit sequence bit-exact.

Source files
------------

// File: rtl/block_interleaver.sv
// Transmit-side block interleaver: row-wise fill, column-wise drain in SYM_W-bit symbols.
// Ports: clk, reset (sync, active-high), in_valid/in_bit/in_ready (serial input), data_ready/out_bits (symbol output).
module block_interleaver #(
  parameter int ROWS  = 8,
  parameter int COLS  = 16,
  parameter int SYM_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  output logic             data_ready,
  output logic [SYM_W-1:0] out_bits
);

  localparam int N    = ROWS * COLS;
  localparam int NSYM = N / SYM_W;
  localparam int NW   = $clog2(N);
  localparam int SW   = $clog2(NSYM);

  typedef enum logic {IDLE, EMIT} state_t;

  logic [N-1:0]     mem_q [2];
  logic [NW-1:0]    wr_cnt_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [1:0]       full_q, full_d;
  state_t           state_q;
  logic [SW-1:0]    sym_cnt_q;
  logic             dr_q;
  logic [SYM_W-1:0] sym_q, sym_d;

  logic          accept;
  logic          wr_last;
  logic          rd_last;
  logic          rd_sel;
  logic [SW-1:0] rd_idx;
  int            m_v, n_v;

  assign in_ready   = ~full_q[wr_bank_q];
  assign accept     = in_valid & in_ready;
  assign wr_last    = accept && (wr_cnt_q == NW'(N - 1));
  assign rd_last    = (state_q == EMIT) &&
                      (sym_cnt_q == SW'(NSYM - 1));
  assign data_ready = dr_q;
  assign out_bits   = sym_q;

  // Select the symbol that will be on the output after the next edge.
  always_comb begin
    rd_sel = rd_bank_q;
    rd_idx = '0;
    if (state_q == EMIT) begin
      if (rd_last) begin
        rd_sel = ~rd_bank_q;
      end else begin
        rd_idx = sym_cnt_q + SW'(1);
      end
    end
    sym_d = '0;
    m_v   = 0;
    n_v   = 0;
    // Earliest interleaved index is shifted in first, ending up on the MSB.
    for (int j = 0; j < SYM_W; j++) begin
      m_v   = int'(rd_idx) * SYM_W + j;
      n_v   = (m_v % ROWS) * COLS + m_v / ROWS;
      sym_d = (sym_d << 1) |
              SYM_W'(mem_q[rd_sel][NW'(n_v)]);
    end
  end

  // Read and write always target different banks, so set and clear
  // on the same edge simply both apply.
  always_comb begin
    full_d = full_q;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_bank_q][wr_cnt_q] <= in_bit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      dr_q      <= 1'b0;
      sym_q     <= '0;
    end else begin
      full_q <= full_d;
      if (accept) begin
        if (wr_last) begin
          wr_cnt_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else begin
          wr_cnt_q <= wr_cnt_q + NW'(1);
        end
      end
      unique case (state_q)
        IDLE: begin
          if (full_q[rd_bank_q]) begin
            state_q   <= EMIT;
            sym_cnt_q <= '0;
            dr_q      <= 1'b1;
            sym_q     <= sym_d;
          end else begin
            dr_q  <= 1'b0;
            sym_q <= '0;
          end
        end
        EMIT: begin
          if (rd_last) begin
            rd_bank_q <= ~rd_bank_q;
            if (full_q[~rd_bank_q]) begin
              sym_cnt_q <= '0;
              dr_q      <= 1'b1;
              sym_q     <= sym_d;
            end else begin
              state_q <= IDLE;
              dr_q    <= 1'b0;
              sym_q   <= '0;
            end
          end else begin
            sym_cnt_q <= sym_cnt_q + SW'(1);
            dr_q      <= 1'b1;
            sym_q     <= sym_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_block_interleaver.sv
// Directed self-checking bench for block_interleaver.
// Drives serial blocks, collects symbols and compares against a column-read model.
module tb_block_interleaver;

  localparam int ROWS  = 8;
  localparam int COLS  = 16;
  localparam int SYM_W = 4;
  localparam int N     = 128;
  localparam int NSYM  = 32;

  localparam logic [127:0] B1 =
    128'h3C3C_C3C3_CCCC_3333_C5AC_368C_0DDE_3EFC;
  localparam logic [127:0] B3A =
    128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] B3B =
    128'hDEAD_BEEF_0F1E_2D3C_A5A5_5A5A_9669_7E81;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic       data_ready;
  logic [3:0] out_bits;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [3:0] syms[$];
  logic [3:0] s1_syms[$];
  int         starts[$];
  int         lens[$];
  int         cur_len    = 0;
  bit         prev_dr    = 1'b0;
  int         idle_bad   = 0;
  int         ready_drop = 0;
  int         last_acc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  block_interleaver #(
    .ROWS (ROWS),
    .COLS (COLS),
    .SYM_W(SYM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_ready  (in_ready),
    .data_ready(data_ready),
    .out_bits  (out_bits)
  );

  always @(negedge clk) begin
    if (data_ready) begin
      if (!prev_dr) starts.push_back(cyc);
      syms.push_back(out_bits);
      cur_len++;
    end else begin
      if (prev_dr) begin
        lens.push_back(cur_len);
        cur_len = 0;
      end
      if (out_bits !== 4'h0) idle_bad++;
    end
    prev_dr = data_ready;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_sym(
      input logic [127:0] b, input int k);
    logic [3:0] s;
    int m, r, c, n;
    s = 4'h0;
    for (int j = 0; j < SYM_W; j++) begin
      m = SYM_W * k + j;
      r = m % ROWS;
      c = m / ROWS;
      n = r * COLS + c;
      s = {s[2:0], b[7'(127 - n)]};
    end
    return s;
  endfunction

  // Inverse permutation: rebuild the serial block from symbols.
  function automatic logic [127:0] deint(input int base);
    logic [127:0] rec;
    logic [3:0]   s;
    int m, n;
    rec = '0;
    for (int k = 0; k < NSYM; k++) begin
      s = syms[base + k];
      for (int j = 0; j < SYM_W; j++) begin
        m = SYM_W * k + j;
        n = (m % ROWS) * COLS + m / ROWS;
        rec[7'(127 - n)] = s[2'(3 - j)];
      end
    end
    return rec;
  endfunction

  task automatic send_bits(input logic [127:0] b,
                           input int nbits,
                           input bit gaps);
    bit acc;
    int guard;
    for (int n = 0; n < nbits; n++) begin
      in_bit = b[7'(127 - n)];
      guard  = 0;
      do begin
        in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (in_valid && !in_ready) ready_drop++;
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        guard++;
      end while (!acc && guard < 1000);
      if (!acc) begin
        chk("accept_timeout", 128'(acc), 128'h1);
        n = nbits;
      end
      last_acc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_syms(input int cnt);
    int g;
    g = 0;
    while (syms.size() < cnt && g < 600) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic check_block(input string tag,
                             input logic [127:0] b,
                             input int base);
    for (int k = 0; k < NSYM; k++)
      chk($sformatf("%s_sym%0d", tag, k),
          128'(syms[base + k]), 128'(model_sym(b, k)));
  endtask

  task automatic clear_q();
    syms.delete();
    starts.delete();
    lens.delete();
    idle_bad = 0;
  endtask

  initial begin
    int t1;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_ready", 128'(data_ready), 128'h0);
    chk("rst_out_bits", 128'(out_bits), 128'h0);
    chk("rst_in_ready", 128'(in_ready), 128'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Scenario 1: reference block, continuous valid.
    clear_q();
    send_bits(B1, N, 1'b0);
    t1 = last_acc;
    wait_syms(NSYM);
    chk("s1_count", 128'(syms.size()), 128'(NSYM));
    chk("s1_sym0", 128'(syms[0]), 128'h6);
    chk("s1_sym1", 128'(syms[1]), 128'h8);
    check_block("s1", B1, 0);
    chk("s1_bursts", 128'(starts.size()), 128'h1);
    chk("s1_latency", 128'(starts[0]), 128'(t1 + 1));
    chk("s1_len", 128'(lens[0]), 128'(NSYM));
    chk("s1_idle_zero", 128'(idle_bad), 128'h0);
    // Scenario 6: inverse permutation restores the input.
    chk("s6_loopback", deint(0), B1);
    s1_syms = syms;

    // Scenario 2: single one at n=17 lands at m=9.
    clear_q();
    send_bits(128'h1 << (127 - 17), N, 1'b0);
    wait_syms(NSYM);
    chk("s2_count", 128'(syms.size()), 128'(NSYM));
    for (int k = 0; k < NSYM; k++)
      chk($sformatf("s2_sym%0d", k), 128'(syms[k]),
          (k == 2) ? 128'h4 : 128'h0);

    // Scenario 3: two blocks back-to-back.
    clear_q();
    ready_drop = 0;
    send_bits(B3A, N, 1'b0);
    send_bits(B3B, N, 1'b0);
    t1 = last_acc;
    wait_syms(2 * NSYM);
    chk("s3_ready_drop", 128'(ready_drop), 128'h0);
    chk("s3_count", 128'(syms.size()), 128'(2 * NSYM));
    chk("s3_bursts", 128'(lens.size()), 128'h2);
    chk("s3_len0", 128'(lens[0]), 128'(NSYM));
    chk("s3_len1", 128'(lens[1]), 128'(NSYM));
    chk("s3_latency1", 128'(starts[1]), 128'(t1 + 1));
    check_block("s3a", B3A, 0);
    check_block("s3b", B3B, NSYM);
    chk("s3_idle_zero", 128'(idle_bad), 128'h0);

    // Scenario 4: random valid gaps, same output as scenario 1.
    clear_q();
    send_bits(B1, N, 1'b1);
    wait_syms(NSYM);
    chk("s4_count", 128'(syms.size()), 128'(NSYM));
    for (int k = 0; k < NSYM; k++)
      chk($sformatf("s4_sym%0d", k), 128'(syms[k]),
          128'(s1_syms[k]));

    // Scenario 5: reset discards a 60-bit partial block.
    clear_q();
    send_bits(B3A, 60, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("s5_rst_in_ready", 128'(in_ready), 128'h1);
    chk("s5_rst_dr", 128'(data_ready), 128'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("s5_no_partial", 128'(syms.size()), 128'h0);
    send_bits(B3B, N, 1'b0);
    wait_syms(NSYM);
    chk("s5_count", 128'(syms.size()), 128'(NSYM));
    check_block("s5", B3B, 0);
    chk("s5_loopback", deint(0), B3B);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
